// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and counter sizing.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

    // One extra bit so the counter can represent WIDTH itself.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/serial_fa_cell.sv
// One-bit full-adder cell used by the serial adder datapath.
module serial_fa_cell (
    input  logic x,
    input  logic y,
    input  logic c,
    output logic s,
    output logic co
);

    assign s  = x ^ y ^ c;
    assign co = (x & y) | (x & c) | (y & c);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one operand bit per clock, LSB first, through a single full-adder cell.
// Optional subtract mode is enabled with macro SERIAL_ADDER_SUB_EN.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state_r;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [WIDTH-1:0] sum_r;
    logic             carry_r;
    logic [CNT_W-1:0] cnt_r;
    logic             busy_r;
    logic             done_r;

    logic [WIDTH-1:0] b_load_s;
    logic             c_load_s;
    logic             fa_s_s;
    logic             fa_co_s;

`ifdef SERIAL_ADDER_SUB_EN
    // Subtraction is a + ~b + 1, so invert B at load time and force the carry.
    always_comb begin
        b_load_s = b;
        c_load_s = cin;
        if (sub) begin
            b_load_s = ~b;
            c_load_s = 1'b1;
        end else begin
            b_load_s = b;
            c_load_s = cin;
        end
    end
`else
    logic unused_sub_s;

    assign b_load_s     = b;
    assign c_load_s     = cin;
    assign unused_sub_s = sub;
`endif

    serial_fa_cell u_fa (
        .x  (a_sh_r[0]),
        .y  (b_sh_r[0]),
        .c  (carry_r),
        .s  (fa_s_s),
        .co (fa_co_s)
    );

    // Control FSM and serial datapath with registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            a_sh_r  <= '0;
            b_sh_r  <= '0;
            sum_r   <= '0;
            carry_r <= 1'b0;
            cnt_r   <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        a_sh_r  <= a;
                        b_sh_r  <= b_load_s;
                        carry_r <= c_load_s;
                        cnt_r   <= '0;
                        busy_r  <= 1'b1;
                        state_r <= RUN;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    a_sh_r  <= {1'b0, a_sh_r[WIDTH-1:1]};
                    b_sh_r  <= {1'b0, b_sh_r[WIDTH-1:1]};
                    sum_r   <= {fa_s_s, sum_r[WIDTH-1:1]};
                    carry_r <= fa_co_s;
                    cnt_r   <= cnt_r + CNT_W'(1);
                    if (cnt_r == CNT_LAST) begin
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                        state_r <= RUN;
                    end
                end
                DONE: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign sum  = sum_r;
    assign cout = carry_r;

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand/result width in bits; legal range 2..32.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  operation request; accepted only in IDLE.
REQ-005 SHALL have port a  input  WIDTH  operand A, sampled at the acceptance edge only.
REQ-006 SHALL have port b  input  WIDTH  operand B, sampled at the acceptance edge only.
REQ-007 SHALL have port cin  input  1  initial carry, sampled at the acceptance edge only.
REQ-008 SHALL have port sub  input  1  subtract request; always present, honoured only per REQ-024.
REQ-009 SHALL have port busy  output  1  high while bits are being processed.
REQ-010 SHALL have port done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port sum  output  WIDTH  result, modulo 2^WIDTH.
REQ-012 SHALL have port cout  output  1  carry out of the MSB.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE after WIDTH RUN cycles; DONE->IDLE unconditionally after one cycle.
REQ-014 SHALL, on start=1 in IDLE at edge n, load a and b into right-shifting registers, cin into the carry flop, clear the bit counter, and enter RUN.
REQ-015 SHALL, on each RUN edge, add LSB(A), LSB(B) and carry in one full-adder cell, shift the sum bit into the MSB of the result register, shift A and B right by one, update carry, and increment the counter.
REQ-016 SHALL process bits LSB-first; bit i is produced at edge n+1+i.
REQ-017 SHALL enter DONE at edge n+WIDTH; done=1 and sum/cout valid for exactly the cycle after that edge.
REQ-018 SHALL drive busy=1 exactly while in RUN, and done=1 exactly while in DONE.
REQ-019 SHALL hold sum and cout stable from DONE until the next accepted start.
REQ-020 SHALL ignore start while in RUN or DONE; no queuing. A start in the IDLE cycle right after DONE is accepted.
REQ-021 SHALL ignore changes on a, b, cin and sub after the acceptance edge.
REQ-022 SHALL wrap on overflow: sum=(a+b+cin) mod 2^WIDTH, with cout=bit WIDTH of the full sum.

Reset
REQ-023 SHALL, while rst=1 (including mid-RUN), force state IDLE, busy=0, done=0, sum=0, cout=0, counter=0, and clear the shift and carry registers. An aborted operation SHALL produce no done.

Configuration
REQ-024 SHALL honour macro SERIAL_ADDER_SUB_EN. When it is defined, sub is sampled with the operands. If sub=1, B bits enter the cell inverted, the initial carry is forced to 1 (cin ignored), sum=(a-b) mod 2^WIDTH, and cout=1 means no borrow. When the macro is undefined, sub is ignored and the block only adds.

Structure
REQ-025 SHALL place the state encoding (IDLE=2'b00, RUN=2'b01, DONE=2'b10) and the counter-width constant ($clog2(WIDTH)+1) in package serial_adder_pkg.
REQ-026 SHALL instantiate exactly one combinational 1-bit sub-module serial_fa_cell, with sum=x^y^c and co=majority(x,y,c).

Verification (WIDTH=8)
REQ-027 SHALL cover: a=8'h0F, b=8'h01, cin=0, start at edge n -> busy for 8 cycles, then done=1 after edge n+8, sum=8'h10, cout=0.
REQ-028 SHALL cover: a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1; a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
REQ-029 SHALL cover: start re-pulsed during RUN with a=8'h22, b=8'h11 -> ignored, result matches the first operands, exactly one done.
REQ-030 SHALL cover: rst pulsed at the 4th RUN cycle -> busy=0, sum=0, cout=0, no done; a following start with a=8'h03, b=8'h04 completes with sum=8'h07.
REQ-031 SHALL cover, with SERIAL_ADDER_SUB_EN defined and sub=1: a=8'h05, b=8'h07 -> sum=8'hFE, cout=0; a=8'h07, b=8'h05 -> sum=8'h02, cout=1.
REQ-032 SHALL cover: start held high continuously for 3 operations -> back-to-back operations with one idle cycle between each DONE and the next RUN; done pulses spaced 10 cycles apart.
